fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the byte address loaded into the PC on reset (multiple of 4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port imem_addr, output, 6, word address to the instruction memory, equal to pc[7:2].
REQ-005 The block SHALL have port imem_data, input, 32, combinational read data returned by the instruction memory for imem_addr.
REQ-006 The block SHALL have port br_taken, input, 1, redirect request from the execute stage.
REQ-007 The block SHALL have port br_target, input, 8, redirect byte address.
REQ-008 The block SHALL have port if_ready, input, 1, downstream (decode) can accept this cycle.
REQ-009 The block SHALL have port if_valid, output, 1, if_inst and if_pc hold a valid instruction.
REQ-010 The block SHALL have port if_inst, output, 32, fetched instruction word.
REQ-011 The block SHALL have port if_pc, output, 8, byte address of if_inst.
REQ-012 The block SHALL have port fault, output, 1, sticky fetch fault flag (see Configuration).

Function
REQ-013 The block SHALL keep an 8-bit PC register and an output register set {if_valid, if_inst, if_pc}.
REQ-014 The block SHALL define a handshake transfer as if_valid && if_ready in the same cycle.
REQ-015 The block SHALL advance when (!if_valid || if_ready): if_inst<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-016 The block SHALL hold pc, if_inst, if_pc and if_valid=1 unchanged while if_valid && !if_ready (stall); if_inst SHALL NOT change while stalled.
REQ-017 The block SHALL give fetch latency of exactly one cycle: the word at pc appears on if_inst the cycle after pc is presented.
REQ-018 The block SHALL wrap pc modulo 256: 8'hFC+4 yields 8'h00, imem_addr 63 followed by 0.
REQ-019 The block SHALL, on br_taken=1, set pc<=br_target and if_valid<=0 (one-cycle bubble) regardless of if_ready or stall state.
REQ-020 The block SHALL give br_taken priority over advance and stall when both apply in the same cycle; the word read that cycle is discarded.
REQ-021 The block SHALL use FSM states RUN and FAULT; RUN is the reset state, FAULT is entered only per REQ-027 and left only by reset.
REQ-022 The block SHALL, in FAULT, hold pc, force if_valid=0, ignore br_taken and keep fault=1.

Reset
REQ-023 The block SHALL, when rst=0 at a rising clk edge, set pc=RESET_PC, if_valid=0, if_inst=32'h0, if_pc=8'h00, fault=0, state=RUN.
REQ-024 The block SHALL give reset priority over br_taken, stall and FAULT; reset mid-stall or mid-redirect discards all in-flight state.
REQ-025 The block SHALL fetch from RESET_PC in the first cycle with rst=1, with if_valid=1 one cycle later.

Configuration
REQ-026 The block SHALL compile the misaligned-target check only when macro FETCH_MISALIGN_CHK_EN is defined.
REQ-027 The block SHALL, with FETCH_MISALIGN_CHK_EN defined, treat br_taken with br_target[1:0]!=0 as a fault: state<=FAULT, fault<=1, if_valid<=0, pc unchanged.
REQ-028 The block SHALL, without FETCH_MISALIGN_CHK_EN, load pc<={br_target[7:2],2'b00}, tie fault to 0 and never enter FAULT.

Verification
REQ-029 The bench SHALL cover reset then free run with memory word n = 32'hA000_0000+n, if_ready=1: if_valid rises cycle 1, if_inst sequence A000_0000, A000_0001, A000_0002, with if_pc 00, 04, 08.
REQ-030 The bench SHALL cover a stall: if_ready=0 for 3 cycles while if_inst=A000_0002: if_inst, if_pc=08 and imem_addr=3 stay constant, then resume with A000_0003.
REQ-031 The bench SHALL cover a redirect: br_taken=1, br_target=8'h40 while stalled: next cycle if_valid=0, imem_addr=16; following cycle if_inst=A000_0010, if_pc=40.
REQ-032 The bench SHALL cover wrap: branch to 8'hF8, run: if_pc F8, FC, 00, 04 with words A000_003E, A000_003F, A000_0000, A000_0001.
REQ-033 The bench SHALL cover a misaligned target: br_target=8'h42; with FETCH_MISALIGN_CHK_EN fault=1 and if_valid stays 0 until rst=0; without it if_pc=40 and fault stays 0.
REQ-034 The bench SHALL cover reset mid-stream: rst=0 for one cycle while if_valid=1: all outputs at reset values next cycle, refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-cycle fetch from a combinational imem, output holding
// register with valid/ready handshake. Optional misaligned-target fault via FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [7:0]  if_pc,
  output logic        fault
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  ipc_q, ipc_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      StFault: begin
        valid_d = 1'b0;
      end
      StRun: begin
        if (br_taken) begin
          // Redirect wins over advance/stall; the word read this cycle is dropped.
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
          if (br_target[1:0] != 2'b00) begin
            state_d = StFault;
          end else begin
            pc_d = br_target;
          end
`else
          pc_d = {br_target[7:2], 2'b00};
`endif
        end else if (!valid_q || if_ready) begin
          inst_d  = imem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 8'd4;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      ipc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_addr = pc_q[7:2];
  assign if_valid  = valid_q;
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fault = (state_q == StFault);
`else
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^br_target[1:0];
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, all checked per cycle against a
// queue of expectations produced by a behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [7:0]  if_pc;
  logic        fault;

  int total = 0;
  int bad   = 0;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_ready  (if_ready),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .fault     (fault)
  );

  // Memory word n holds A000_0000 + n.
  assign imem_data = 32'hA000_0000 + {26'h0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] inst;
    logic [7:0]  pc;
    logic [5:0]  addr;
    logic        f;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state: byte PC, output slot, sticky fault.
  int          m_pc;
  bit          m_v;
  logic [31:0] m_inst;
  int          m_ipc;
  bit          m_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, queue what the outputs must show after it.
  task automatic cyc(input bit r, input bit b, input logic [7:0] t, input bit rdy);
    exp_t e;
    rst = r; br_taken = b; br_target = t; if_ready = rdy;
    if (!r) begin
      m_pc = 0; m_v = 0; m_inst = 32'h0; m_ipc = 0; m_f = 0;
    end else if (m_f) begin
      m_v = 0;
    end else if (b) begin
      m_v = 0;
      if (ChkEn && (t % 4 != 0)) m_f = 1;
      else m_pc = (int'(t) / 4) * 4;
    end else if (!m_v || rdy) begin
      m_inst = 32'hA000_0000 + 32'(m_pc / 4);
      m_ipc  = m_pc;
      m_v    = 1;
      m_pc   = (m_pc + 4) % 256;
    end
    @(posedge clk);
    #1;
    e.v = m_v; e.inst = m_inst; e.pc = 8'(m_ipc); e.addr = 6'(m_pc / 4); e.f = m_f;
    exp_q.push_back(e);
  endtask

  task automatic expect_out(input string name, input bit v, input logic [31:0] inst,
                            input logic [7:0] pc);
    chk({name, "_valid"}, {31'h0, if_valid}, {31'h0, v});
    if (v) begin
      chk({name, "_inst"}, if_inst, inst);
      chk({name, "_pc"}, {24'h0, if_pc}, {24'h0, pc});
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_valid", {31'h0, if_valid}, {31'h0, e.v});
      chk("sb_fault", {31'h0, fault}, {31'h0, e.f});
      chk("sb_addr", {26'h0, imem_addr}, {26'h0, e.addr});
      if (e.v) begin
        chk("sb_inst", if_inst, e.inst);
        chk("sb_pc", {24'h0, if_pc}, {24'h0, e.pc});
      end
    end
  end

  initial begin
    rst = 1'b0; br_taken = 1'b0; br_target = 8'h00; if_ready = 1'b0;
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", {24'h0, if_pc}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_addr", {26'h0, imem_addr}, 32'h0);

    // Free run
    cyc(1, 0, 8'h00, 1); expect_out("run0", 1, 32'hA000_0000, 8'h00);
    cyc(1, 0, 8'h00, 1); expect_out("run1", 1, 32'hA000_0001, 8'h04);
    cyc(1, 0, 8'h00, 1); expect_out("run2", 1, 32'hA000_0002, 8'h08);

    // Stall for three cycles, then resume
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 8'h00, 0);
      expect_out("stall", 1, 32'hA000_0002, 8'h08);
      chk("stall_addr", {26'h0, imem_addr}, 32'd3);
    end
    cyc(1, 0, 8'h00, 1); expect_out("resume", 1, 32'hA000_0003, 8'h0C);

    // Redirect while stalled
    cyc(1, 0, 8'h00, 0);
    cyc(1, 1, 8'h40, 0);
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    chk("redir_addr", {26'h0, imem_addr}, 32'd16);
    cyc(1, 0, 8'h00, 1); expect_out("redir_tgt", 1, 32'hA000_0010, 8'h40);

    // Wrap past the top of the address space
    cyc(1, 1, 8'hF8, 1);
    cyc(1, 0, 8'h00, 1); expect_out("wrap0", 1, 32'hA000_003E, 8'hF8);
    cyc(1, 0, 8'h00, 1); expect_out("wrap1", 1, 32'hA000_003F, 8'hFC);
    cyc(1, 0, 8'h00, 1); expect_out("wrap2", 1, 32'hA000_0000, 8'h00);
    cyc(1, 0, 8'h00, 1); expect_out("wrap3", 1, 32'hA000_0001, 8'h04);

    // Misaligned target
    cyc(1, 1, 8'h42, 1);
    chk("mis_valid", {31'h0, if_valid}, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_fault", {31'h0, fault}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 8'h10, 1);
      chk("mis_hold_valid", {31'h0, if_valid}, 32'h0);
      chk("mis_hold_fault", {31'h0, fault}, 32'h1);
      chk("mis_hold_addr", {26'h0, imem_addr}, 32'd2);
    end
    cyc(0, 0, 8'h00, 1);
    chk("mis_clear", {31'h0, fault}, 32'h0);
`else
    cyc(1, 0, 8'h00, 1);
    expect_out("mis_tgt", 1, 32'hA000_0010, 8'h40);
    chk("mis_nofault", {31'h0, fault}, 32'h0);
`endif

    // Reset mid-stream
    cyc(1, 0, 8'h00, 1);
    chk("mid_pre_valid", {31'h0, if_valid}, 32'h1);
    cyc(0, 0, 8'h00, 1);
    chk("mid_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_inst", if_inst, 32'h0);
    chk("mid_pc", {24'h0, if_pc}, 32'h0);
    chk("mid_addr", {26'h0, imem_addr}, 32'h0);
    cyc(1, 0, 8'h00, 1); expect_out("mid_refetch", 1, 32'hA000_0000, 8'h00);

    // Random traffic, scoreboard only
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0,
          8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
